// File: rtl/fpmul_share_arb.sv
// fpmul_share_arb: round-robin scheduler sharing one combinational FP32 /
// packed-BF16 multiplier between two requesters. Credit-based admission
// guarantees every issued result has a slot in its requester's response FIFO.
// Optional performance counters are enabled by FPMUL_SHARE_ARB_PERF_EN.

package fpmul_share_arb_pkg;
    typedef enum logic {FP32 = 1'b0, FP16 = 1'b1} fp_fmt_e;
    typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2} fp_op_e;
endpackage

module fpmul_share_arb
    import fpmul_share_arb_pkg::*;
#(
    parameter int unsigned LAT       = 1,
    parameter int unsigned RSP_DEPTH = 4,
    parameter int unsigned TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef FPMUL_SHARE_ARB_PERF_EN
    input  logic             perf_clr,
    output logic [15:0]      perf_grant0,
    output logic [15:0]      perf_grant1,
    output logic [15:0]      perf_conflict,
`endif
    input  logic             req0_valid,
    output logic             req0_ready,
    input  fp_fmt_e          req0_fmt,
    input  logic [31:0]      req0_x,
    input  logic [31:0]      req0_y,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  fp_fmt_e          req1_fmt,
    input  logic [31:0]      req1_x,
    input  logic [31:0]      req1_y,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [31:0]      rsp0_r,
    output logic [TAG_W-1:0] rsp0_tag,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp1_r,
    output logic [TAG_W-1:0] rsp1_tag,
    output fp_op_e           mul_opcode,
    output fp_fmt_e          mul_fmt,
    output logic [31:0]      mul_x,
    output logic [31:0]      mul_y,
    input  logic [31:0]      mul_r
);

    localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1) + 1;

    logic [1:0]    req_valid, rsp_ready, elig, grant, wr_en, pop;
    logic          rr_q, rr_d;
    logic [CW-1:0] infl_q [2];
    logic [CW-1:0] infl_d [2];
    logic [CW-1:0] occ_q  [2];
    logic [CW-1:0] occ_d  [2];

    logic             s0_valid_q, s0_id_q;
    fp_fmt_e          s0_fmt_q;
    logic [31:0]      s0_x_q, s0_y_q;
    logic [TAG_W-1:0] s0_tag_q;

    logic             p_valid_q [LAT];
    logic             p_id_q    [LAT];
    logic [31:0]      p_r_q     [LAT];
    logic [TAG_W-1:0] p_tag_q   [LAT];

    logic [31:0]      fifo_r_q   [2][RSP_DEPTH];
    logic [TAG_W-1:0] fifo_tag_q [2][RSP_DEPTH];
    logic [PW-1:0]    wr_ptr_q [2];
    logic [PW-1:0]    rd_ptr_q [2];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // Credit check on registered counts, FIFO write from the last pipe stage, pop
    always_comb begin
        elig  = '0;
        wr_en = '0;
        pop   = '0;
        for (int unsigned n = 0; n < 2; n++) begin
            elig[n]  = req_valid[n] && ((infl_q[n] + occ_q[n]) < CW'(RSP_DEPTH));
            wr_en[n] = p_valid_q[LAT-1] && (p_id_q[LAT-1] == 1'(n));
            pop[n]   = (occ_q[n] != '0) && rsp_ready[n];
        end
    end

    // Round-robin grant; ready is held low while reset is asserted
    always_comb begin
        grant = '0;
        rr_d  = rr_q;
        if (rst_n) begin
            if (elig[0] && (!elig[1] || !rr_q)) begin
                grant[0] = 1'b1;
            end else if (elig[1]) begin
                grant[1] = 1'b1;
            end
        end
        if (grant[0]) begin
            rr_d = 1'b1;
        end else if (grant[1]) begin
            rr_d = 1'b0;
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // In-flight and occupancy counters net simultaneous increments/decrements
    always_comb begin
        for (int unsigned n = 0; n < 2; n++) begin
            infl_d[n] = infl_q[n] + CW'(grant[n]) - CW'(wr_en[n]);
            occ_d[n]  = occ_q[n] + CW'(wr_en[n]) - CW'(pop[n]);
        end
    end

    // Arbiter pointer, counters and FIFO pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
            for (int unsigned n = 0; n < 2; n++) begin
                infl_q[n]   <= '0;
                occ_q[n]    <= '0;
                wr_ptr_q[n] <= '0;
                rd_ptr_q[n] <= '0;
            end
        end else begin
            rr_q <= rr_d;
            for (int unsigned n = 0; n < 2; n++) begin
                infl_q[n] <= infl_d[n];
                occ_q[n]  <= occ_d[n];
                if (wr_en[n]) wr_ptr_q[n] <= ptr_inc(wr_ptr_q[n]);
                if (pop[n])   rd_ptr_q[n] <= ptr_inc(rd_ptr_q[n]);
            end
        end
    end

    // Issue register: operands of the granted request, zeros when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q <= 1'b0;
            s0_id_q    <= 1'b0;
            s0_fmt_q   <= FP32;
            s0_x_q     <= '0;
            s0_y_q     <= '0;
            s0_tag_q   <= '0;
        end else begin
            s0_valid_q <= |grant;
            s0_id_q    <= grant[1];
            s0_fmt_q   <= grant[1] ? req1_fmt : (grant[0] ? req0_fmt : FP32);
            s0_x_q     <= grant[1] ? req1_x   : (grant[0] ? req0_x   : '0);
            s0_y_q     <= grant[1] ? req1_y   : (grant[0] ? req0_y   : '0);
            s0_tag_q   <= grant[1] ? req1_tag : (grant[0] ? req0_tag : '0);
        end
    end

    assign mul_opcode = OP_MUL;
    assign mul_fmt    = s0_fmt_q;
    assign mul_x      = s0_x_q;
    assign mul_y      = s0_y_q;

    // Result pipeline: captures the product, then shifts every cycle without stalling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                p_valid_q[i] <= 1'b0;
                p_id_q[i]    <= 1'b0;
                p_r_q[i]     <= '0;
                p_tag_q[i]   <= '0;
            end
        end else begin
            p_valid_q[0] <= s0_valid_q;
            p_id_q[0]    <= s0_id_q;
            p_r_q[0]     <= mul_r;
            p_tag_q[0]   <= s0_tag_q;
            for (int unsigned i = 1; i < LAT; i++) begin
                p_valid_q[i] <= p_valid_q[i-1];
                p_id_q[i]    <= p_id_q[i-1];
                p_r_q[i]     <= p_r_q[i-1];
                p_tag_q[i]   <= p_tag_q[i-1];
            end
        end
    end

    // Response FIFO storage; contents are only visible while the FIFO is non-empty
    always_ff @(posedge clk) begin
        for (int unsigned n = 0; n < 2; n++) begin
            if (wr_en[n]) begin
                fifo_r_q[n][wr_ptr_q[n]]   <= p_r_q[LAT-1];
                fifo_tag_q[n][wr_ptr_q[n]] <= p_tag_q[LAT-1];
            end
        end
    end

    assign rsp0_valid = (occ_q[0] != '0);
    assign rsp1_valid = (occ_q[1] != '0);
    assign rsp0_r     = rsp0_valid ? fifo_r_q[0][rd_ptr_q[0]]   : '0;
    assign rsp0_tag   = rsp0_valid ? fifo_tag_q[0][rd_ptr_q[0]] : '0;
    assign rsp1_r     = rsp1_valid ? fifo_r_q[1][rd_ptr_q[1]]   : '0;
    assign rsp1_tag   = rsp1_valid ? fifo_tag_q[1][rd_ptr_q[1]] : '0;

`ifdef FPMUL_SHARE_ARB_PERF_EN
    logic [15:0] perf_g0_q, perf_g1_q, perf_cf_q;

    // Saturating grant/conflict counters; clear has priority over counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_g0_q <= '0;
            perf_g1_q <= '0;
            perf_cf_q <= '0;
        end else if (perf_clr) begin
            perf_g0_q <= '0;
            perf_g1_q <= '0;
            perf_cf_q <= '0;
        end else begin
            if (grant[0] && (perf_g0_q != '1)) perf_g0_q <= perf_g0_q + 1'b1;
            if (grant[1] && (perf_g1_q != '1)) perf_g1_q <= perf_g1_q + 1'b1;
            if (req0_valid && req1_valid && (perf_cf_q != '1)) perf_cf_q <= perf_cf_q + 1'b1;
        end
    end

    assign perf_grant0   = perf_g0_q;
    assign perf_grant1   = perf_g1_q;
    assign perf_conflict = perf_cf_q;
`endif

endmodule

// File: tb/tb_fpmul_share_arb.sv
// Scoreboard bench for fpmul_share_arb: drivers push expected responses on
// acceptance, a monitor pops and compares on every response handshake.
// A behavioural multiplier (normal numbers, truncating) drives mul_r.
module tb_fpmul_share_arb;
    import fpmul_share_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    fp_fmt_e     req0_fmt = FP32, req1_fmt = FP32;
    logic [31:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic [3:0]  req0_tag = '0, req1_tag = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [31:0] rsp0_r, rsp1_r;
    logic [3:0]  rsp0_tag, rsp1_tag;
    fp_op_e      mul_opcode;
    fp_fmt_e     mul_fmt;
    logic [31:0] mul_x, mul_y, mul_r;
`ifdef FPMUL_SHARE_ARB_PERF_EN
    logic        perf_clr = 1'b0;
    logic [15:0] perf_grant0, perf_grant1, perf_conflict;
`endif

    fpmul_share_arb #(.LAT(1), .RSP_DEPTH(4), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef FPMUL_SHARE_ARB_PERF_EN
        .perf_clr(perf_clr), .perf_grant0(perf_grant0), .perf_grant1(perf_grant1),
        .perf_conflict(perf_conflict),
`endif
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fmt(req0_fmt),
        .req0_x(req0_x), .req0_y(req0_y), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fmt(req1_fmt),
        .req1_x(req1_x), .req1_y(req1_y), .req1_tag(req1_tag),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_r(rsp0_r), .rsp0_tag(rsp0_tag),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_r(rsp1_r), .rsp1_tag(rsp1_tag),
        .mul_opcode(mul_opcode), .mul_fmt(mul_fmt), .mul_x(mul_x), .mul_y(mul_y), .mul_r(mul_r)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] r;
        logic [3:0]  tag;
    } exp_t;
    exp_t exp0[$];
    exp_t exp1[$];
    int   glog[$];

    function automatic logic [31:0] fp32_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        logic [22:0] m;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin m = p[46:24]; e = e + 1; end
        else       m = p[45:23];
        return {s, e[7:0], m};
    endfunction

    function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        int          e;
        logic [15:0] p;
        logic [6:0]  m;
        s = a[15] ^ b[15];
        if (a[14:7] == 8'd0 || b[14:7] == 8'd0) return {s, 15'd0};
        p = {8'd0, 1'b1, a[6:0]} * {8'd0, 1'b1, b[6:0]};
        e = int'(a[14:7]) + int'(b[14:7]) - 127;
        if (p[15]) begin m = p[14:8]; e = e + 1; end
        else       m = p[13:7];
        return {s, e[7:0], m};
    endfunction

    assign mul_r = (mul_fmt == FP16) ? {bf16_mul(mul_x[31:16], mul_y[31:16]), bf16_mul(mul_x[15:0], mul_y[15:0])}
                                     : fp32_mul(mul_x, mul_y);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    // Present one request, wait for acceptance, record the expected response
    task automatic send(input int n, input fp_fmt_e f, input logic [31:0] x, input logic [31:0] y,
                        input logic [3:0] tag, input logic [31:0] er, output int unsigned acc);
        int unsigned waited = 0;
        bit          done = 0;
        exp_t        e;
        acc = 0;
        while (!done) begin
            @(negedge clk);
            if (n == 0) begin req0_valid = 1; req0_fmt = f; req0_x = x; req0_y = y; req0_tag = tag; end
            else        begin req1_valid = 1; req1_fmt = f; req1_x = x; req1_y = y; req1_tag = tag; end
            #1;
            if ((n == 0) ? req0_ready : req1_ready) begin
                e.r = er;
                e.tag = tag;
                if (n == 0) exp0.push_back(e); else exp1.push_back(e);
                @(posedge clk);
                #1;
                acc = cyc;
                done = 1;
            end else if (waited++ > 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout req%0d tag %0d: ready stayed 0, expected 1", n, tag);
                done = 1;
            end
            if (done) begin
                if (n == 0) req0_valid = 0; else req1_valid = 0;
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && (exp0.size() != 0 || exp1.size() != 0); i++) @(negedge clk);
        chk("drain_q0", 32'(exp0.size()), 32'd0);
        chk("drain_q1", 32'(exp1.size()), 32'd0);
    endtask

    // Monitor: compare each popped response against the head of its queue
    always begin
        exp_t me;
        @(negedge clk);
        #2;
        if (rst_n && rsp0_valid && rsp0_ready) begin
            if (exp0.size() == 0) begin
                checks++; failures++;
                $display("FAIL rsp0_unexpected: got r=0x%08h tag=%0d, expected no response", rsp0_r, rsp0_tag);
            end else begin
                me = exp0.pop_front();
                chk("rsp0_r", rsp0_r, me.r);
                chk("rsp0_tag", 32'(rsp0_tag), 32'(me.tag));
            end
        end
        if (rst_n && rsp1_valid && rsp1_ready) begin
            if (exp1.size() == 0) begin
                checks++; failures++;
                $display("FAIL rsp1_unexpected: got r=0x%08h tag=%0d, expected no response", rsp1_r, rsp1_tag);
            end else begin
                me = exp1.pop_front();
                chk("rsp1_r", rsp1_r, me.r);
                chk("rsp1_tag", 32'(rsp1_tag), 32'(me.tag));
            end
        end
    end

    // Grant logger: at most one grant per cycle, sequence kept for order checks
    always begin
        @(negedge clk);
        #2;
        if (rst_n && (req0_ready || req1_ready)) begin
            chk("one_grant", 32'(req0_ready && req1_ready), 32'd0);
            glog.push_back(req0_ready ? 0 : 1);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

`ifdef FPMUL_SHARE_ARB_PERF_EN
    task automatic both_cycles(input int ncyc);
        exp_t e;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            req0_valid = 1; req0_fmt = FP32; req0_x = 32'h3FC00000; req0_y = 32'h40000000; req0_tag = 4'hA;
            req1_valid = 1; req1_fmt = FP32; req1_x = 32'h3FC00000; req1_y = 32'h40000000; req1_tag = 4'hB;
            #1;
            e.r = 32'h40400000;
            if (req0_ready) begin e.tag = 4'hA; exp0.push_back(e); end
            if (req1_ready) begin e.tag = 4'hB; exp1.push_back(e); end
        end
        @(negedge clk);
        req0_valid = 0;
        req1_valid = 0;
    endtask
`endif

    initial begin
        int unsigned acc, lat_cyc;
        bit          seen, blocked, stale;
        exp_t        e;

        // Reset values, with a request pending to exercise ready gating
        req0_valid = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_req0_ready", 32'(req0_ready), 32'd0);
        chk("reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("reset_rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("reset_rsp0_r", rsp0_r, 32'd0);
        chk("reset_rsp1_tag", 32'(rsp1_tag), 32'd0);
        chk("reset_mul_x", mul_x, 32'd0);
        chk("reset_mul_y", mul_y, 32'd0);
        chk("reset_mul_fmt", 32'(mul_fmt), 32'(FP32));
        req0_valid = 0;
        @(negedge clk);
        rst_n = 1;
        rsp0_ready = 1;
        rsp1_ready = 1;

        // Both requesters back-to-back: grants alternate starting with 0
        glog.delete();
        fork
            begin
                int unsigned a0;
                send(0, FP32, 32'h3FC00000, 32'h40000000, 4'd1, 32'h40400000, a0);
                send(0, FP32, 32'h40400000, 32'h40800000, 4'd2, 32'h41400000, a0);
                send(0, FP32, 32'h3F800000, 32'hBF800000, 4'd3, 32'hBF800000, a0);
                send(0, FP32, 32'h40000000, 32'h40000000, 4'd4, 32'h40800000, a0);
            end
            begin
                int unsigned a1;
                send(1, FP32, 32'h3FC00000, 32'h3FC00000, 4'd9,  32'h40100000, a1);
                send(1, FP32, 32'hC0000000, 32'h40400000, 4'd10, 32'hC0C00000, a1);
                send(1, FP32, 32'h3F800000, 32'hBF800000, 4'd11, 32'hBF800000, a1);
                send(1, FP32, 32'h3FC00000, 32'h40000000, 4'd12, 32'h40400000, a1);
            end
        join
        wait_drain();
        chk("grant_count", 32'(glog.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < glog.size()) chk($sformatf("grant_order%0d", i), 32'(glog[i]), 32'(i % 2));
        end

        // Single request: issue-cycle operands and response latency
        send(0, FP32, 32'h3FC00000, 32'h40000000, 4'd5, 32'h40400000, acc);
        chk("issue_mul_x", mul_x, 32'h3FC00000);
        chk("issue_mul_y", mul_y, 32'h40000000);
        chk("issue_mul_fmt", 32'(mul_fmt), 32'(FP32));
        chk("mul_opcode", 32'(mul_opcode), 32'(OP_MUL));
        seen = 0;
        lat_cyc = acc + 99;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (rsp0_valid) begin seen = 1; lat_cyc = cyc; end
        end
        chk("rsp0_latency_edges", lat_cyc - acc, 32'd2);
        wait_drain();

        // Packed BF16 requests
        send(1, FP16, 32'h3F804000, 32'h40003F80, 4'd6, 32'h40004000, acc);
        chk("issue_fp16_fmt", 32'(mul_fmt), 32'(FP16));
        chk("issue_fp16_x", mul_x, 32'h3F804000);
        send(0, FP16, 32'h40404000, 32'h40803F80, 4'd7, 32'h41404000, acc);
        chk("issue_fp16_fmt_r0", 32'(mul_fmt), 32'(FP16));
        chk("issue_fp16_y_r0", mul_y, 32'h40803F80);
        wait_drain();

        // Credit exhaustion with rsp0 back-pressured, then drain and resume
        @(negedge clk);
        rsp0_ready = 0;
        send(0, FP32, 32'h3FC00000, 32'h40000000, 4'd1, 32'h40400000, acc);
        send(0, FP32, 32'h40400000, 32'h40800000, 4'd2, 32'h41400000, acc);
        send(0, FP32, 32'h3FC00000, 32'h3FC00000, 4'd3, 32'h40100000, acc);
        send(0, FP32, 32'hC0000000, 32'h40400000, 4'd4, 32'hC0C00000, acc);
        @(negedge clk);
        req0_valid = 1; req0_fmt = FP32; req0_x = 32'h40000000; req0_y = 32'h40000000; req0_tag = 4'd8;
        blocked = 1;
        repeat (6) begin
            #1;
            if (req0_ready) blocked = 0;
            @(negedge clk);
        end
        chk("credit_blocked", 32'(blocked), 32'd1);
        rsp0_ready = 1;
        #1;
        chk("ready_during_first_pop", 32'(req0_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("ready_after_first_pop", 32'(req0_ready), 32'd1);
        if (req0_ready) begin
            e.r = 32'h40800000;
            e.tag = 4'd8;
            exp0.push_back(e);
        end
        @(posedge clk);
        #1;
        req0_valid = 0;
        wait_drain();

        // Reset with three results outstanding
        @(negedge clk);
        rsp0_ready = 0;
        send(0, FP32, 32'h3FC00000, 32'h40000000, 4'd1, 32'h40400000, acc);
        send(0, FP32, 32'h40400000, 32'h40800000, 4'd2, 32'h41400000, acc);
        send(0, FP32, 32'h3F800000, 32'hBF800000, 4'd3, 32'hBF800000, acc);
        chk("rsp0_valid_before_reset", 32'(rsp0_valid), 32'd1);
        req0_valid = 1;
        rst_n = 0;
        #1;
        chk("midrst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("midrst_rsp0_r", rsp0_r, 32'd0);
        chk("midrst_rsp0_tag", 32'(rsp0_tag), 32'd0);
        chk("midrst_mul_x", mul_x, 32'd0);
        chk("midrst_mul_fmt", 32'(mul_fmt), 32'(FP32));
        chk("midrst_req0_ready", 32'(req0_ready), 32'd0);
        exp0.delete();
        exp1.delete();
        req0_valid = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        rsp0_ready = 1;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) stale = 1;
        end
        chk("no_stale_after_reset", 32'(stale), 32'd0);

`ifdef FPMUL_SHARE_ARB_PERF_EN
        // Performance counters: conflict/grant counts, clear, saturation
        @(negedge clk);
        perf_clr = 1;
        @(negedge clk);
        perf_clr = 0;
        both_cycles(10);
        #1;
        chk("perf_conflict_10", 32'(perf_conflict), 32'd10);
        chk("perf_grant0_5", 32'(perf_grant0), 32'd5);
        chk("perf_grant1_5", 32'(perf_grant1), 32'd5);
        wait_drain();
        @(negedge clk);
        perf_clr = 1;
        @(negedge clk);
        perf_clr = 0;
        #1;
        chk("perf_clr_conflict", 32'(perf_conflict), 32'd0);
        chk("perf_clr_grant0", 32'(perf_grant0), 32'd0);
        chk("perf_clr_grant1", 32'(perf_grant1), 32'd0);
        rsp0_ready = 0;
        rsp1_ready = 0;
        both_cycles(65540);
        #1;
        chk("perf_conflict_sat", 32'(perf_conflict), 32'h0000FFFF);
        chk("perf_grant0_credit", 32'(perf_grant0), 32'd4);
        both_cycles(3);
        #1;
        chk("perf_conflict_hold", 32'(perf_conflict), 32'h0000FFFF);
        rsp0_ready = 1;
        rsp1_ready = 1;
        wait_drain();
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
